fw_rv_rr_arbiter: RTL
=====================

Name: fw_rv_rr_arbiter

Overview:
- N-input, 1-output ready/valid stream arbiter with round-robin fairness.
- Lets several initiators share one downstream ready/valid target, for example a shared buffer or bus channel.
- Output is registered by a single skid-free stage, with the same semantics as the team's standard one-entry rv buffer.
- Full throughput: one transfer per cycle when the output is continuously ready.

Parameters:
- WIDTH, 8, payload width in bits.
- N_REQ, 4, number of requesters, 2..16.
- ID_W, 2, width of o_id; must be at least clog2(N_REQ).

Ports:
- clock  in  1  rising-edge clock; single clock domain.
- reset  in  1  synchronous, active-low reset: asserted when 0, sampled on clock rising edge.
- i_dat  in  N_REQ*WIDTH  packed payloads; requester k occupies bits [k*WIDTH +: WIDTH].
- i_valid  in  N_REQ  per-requester valid.
- i_ready  out  N_REQ  per-requester ready.
- o_dat  out  WIDTH  registered payload.
- o_id  out  ID_W  index of the requester that sourced o_dat.
- o_valid  out  1  output valid.
- o_ready  in  1  downstream ready.

Behaviour:
- Reset (reset==0 at a clock edge):
  - o_valid=0, o_dat=0, o_id=0.
  - Round-robin pointer rr_ptr=0.
  - Lock state = UNLOCKED.
  - i_ready: all 0 is not required; it follows the combinational rule below, and with o_valid=0 the slot is free.
- Slot rule: slot_free = !o_valid || o_ready.
- Grant selection (combinational):
  - Search i_valid starting at index rr_ptr, ascending, wrapping N_REQ-1 -> 0.
  - gnt = first asserted index.
  - any_req = |i_valid.
- Ready: i_ready[k] = slot_free && any_req && (gnt==k). At most one bit of i_ready is high.
  - i_ready may depend combinationally on i_valid.
  - o_valid never depends combinationally on any input.
- Transfer into the slot (i_valid[gnt] && i_ready[gnt]):
  - o_dat <= i_dat[gnt].
  - o_id <= gnt.
  - o_valid <= 1.
  - rr_ptr <= (gnt+1) mod N_REQ.
- Drain: o_valid && o_ready with no new transfer -> o_valid <= 0.
- Simultaneous drain and fill in the same cycle: o_valid stays 1 and the new data replaces the old.
- Stall: o_valid && !o_ready -> o_dat and o_id are held stable, all i_ready=0, and rr_ptr is unchanged.
- Latency: accepted input appears on o_valid on the next cycle.
- No request: rr_ptr is unchanged. The pointer only advances on an accepted transfer.
- Fairness: with all requesters continuously valid and o_ready=1, the grant order is 0,1,2,3,0,… and each requester waits at most N_REQ-1 transfers.
- Wrap: when gnt==N_REQ-1, rr_ptr returns to 0.
- Reset mid-operation: a held o_dat is discarded and o_valid drops on the reset edge. No partial state survives.
- Non-power-of-two N_REQ: rr_ptr arithmetic is mod N_REQ. Indices ≥ N_REQ are never granted.

Optional Feature:
- Macro: FW_RV_RR_ARBITER_LOCK_EN.
- When defined, an extra input port i_lock [N_REQ] is added, and arbitration has two states:
  - UNLOCKED: normal round-robin.
  - LOCKED(owner): entered on an accepted transfer from k with i_lock[k]=1; owner=k.
- While LOCKED:
  - gnt is forced to owner.
  - Other requesters see i_ready=0 even if the owner is idle.
  - rr_ptr does not advance.
- Exit: an accepted transfer from the owner with i_lock[owner]=0 returns to UNLOCKED and sets rr_ptr=owner+1.
- Reset forces UNLOCKED.
- When the macro is undefined: the port is absent and behaviour is as above (never locked).

Decomposition:
- Shared header fw_rv_arbiter_defs.svh holds:
  - Lock-state encodings: ARB_UNLOCKED=1'b0, ARB_LOCKED=1'b1.
  - A clog2 helper macro for ID_W checks.
  - Ports use the existing RV port macros for the o_ side.
- Sub-module fw_rv_rr_sel(N_REQ) is the pure combinational rotating-priority picker: inputs req and ptr; outputs gnt and any. It is reusable by future schedulers.

Test Plan (N_REQ=4, WIDTH=8):
- After reset, all i_valid=1 with i_dat = {0x33,0x22,0x11,0x00} and o_ready=1 -> o_dat sequence 0x00,0x11,0x22,0x33,0x00 on consecutive cycles; o_id = 0,1,2,3,0.
- Only requester 2 valid with dat 0xA5, o_ready=0 for 3 cycles -> o_valid=1 with o_dat=0xA5 and o_id=2 stable; i_ready=0000 during the stall; one transfer delivered when o_ready rises.
- rr_ptr=3, requesters 1 and 3 valid -> 3 is granted first, then 1 (wrap check).
- reset driven 0 while o_valid=1 and o_ready=0 -> next cycle o_valid=0 and o_dat=0x00; first post-reset grant goes to the lowest-indexed valid requester.
- LOCK_EN: requester 1 sends 3 beats with i_lock=1,1,0 while requester 0 is continuously valid -> the three beats from 1 are contiguous, then 0 is granted.
- Random valid/ready for 10k cycles -> no lost or duplicated beats, per-requester order preserved, and no requester starved beyond 3 transfers.

Source files
------------

// File: rtl/fw_rv_rr_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// fw_rv_rr_arbiter_pkg
// Shared definitions for the round-robin ready/valid arbiter family.
//   arb_state_e : arbitration lock state (ARB_UNLOCKED / ARB_LOCKED)
//   clog2()     : elaboration-time ceil(log2) used to validate index widths
// -----------------------------------------------------------------------------
package fw_rv_rr_arbiter_pkg;

   typedef enum logic {
      ARB_UNLOCKED = 1'b0,
      ARB_LOCKED   = 1'b1
   } arb_state_e;

   // ceil(log2(value)); a single requester needs zero index bits.
   function automatic int clog2(input int value);
      int result;
      int v;
      result = 0;
      v      = value - 1;
      while (v > 0) begin
         result = result + 1;
         v      = v >> 1;
      end
      return result;
   endfunction

endpackage

// File: rtl/fw_rv_rr_sel.sv
// -----------------------------------------------------------------------------
// fw_rv_rr_sel
// Purely combinational rotating-priority picker. Starting at index ptr and
// walking upwards (wrapping N_REQ-1 -> 0), returns the first asserted request.
// Ports:
//   req [N_REQ]  request vector
//   ptr [PTR_W]  highest-priority index this cycle, must be < N_REQ
//   gnt [PTR_W]  granted index (meaningful only when any=1)
//   any          at least one request asserted
// -----------------------------------------------------------------------------
module fw_rv_rr_sel #(
   parameter int N_REQ = 4,
   parameter int PTR_W = 2
) (
   input  logic [N_REQ-1:0] req,
   input  logic [PTR_W-1:0] ptr,
   output logic [PTR_W-1:0] gnt,
   output logic             any
);

   // Rotate so that index ptr lands on bit 0; a plain priority encoder on the
   // rotated vector then yields the distance from ptr to the winner.
   logic [2*N_REQ-1:0] req_dbl;
   logic [2*N_REQ-1:0] req_shift;
   logic [N_REQ-1:0]   req_rot;
   logic [PTR_W-1:0]   offset;
   logic [PTR_W:0]     sum;

   assign req_dbl   = {req, req};
   assign req_shift = req_dbl >> ptr;
   assign req_rot   = req_shift[N_REQ-1:0];
   assign any       = |req;

   always_comb begin
      offset = '0;
      for (int i = N_REQ - 1; i >= 0; i--) begin
         if (req_rot[i]) begin
            offset = PTR_W'(i);
         end
      end
      // ptr + offset < 2*N_REQ, so one conditional subtract gives mod N_REQ
      // even for non-power-of-two N_REQ.
      sum = {1'b0, ptr} + {1'b0, offset};
      if (sum >= (PTR_W+1)'(N_REQ)) begin
         sum = sum - (PTR_W+1)'(N_REQ);
      end
      gnt = sum[PTR_W-1:0];
   end

endmodule

// File: rtl/fw_rv_rr_arbiter.sv
// -----------------------------------------------------------------------------
// fw_rv_rr_arbiter
// N-input, 1-output ready/valid arbiter with round-robin fairness and a single
// registered output slot (full throughput when o_ready stays high).
// Optional build macro FW_RV_RR_ARBITER_LOCK_EN adds i_lock, letting a
// requester hold the grant across several beats.
// Ports:
//   clock                 rising-edge clock
//   reset                 synchronous, active-low
//   i_dat  [N_REQ*WIDTH]  packed payloads, requester k at [k*WIDTH +: WIDTH]
//   i_valid[N_REQ]        per-requester valid
//   i_lock [N_REQ]        (LOCK_EN only) keep the grant after this beat
//   i_ready[N_REQ]        per-requester ready, at most one bit high
//   o_dat  [WIDTH]        registered payload
//   o_id   [ID_W]         index of the requester that sourced o_dat
//   o_valid               output valid (registered)
//   o_ready               downstream ready
// -----------------------------------------------------------------------------
module fw_rv_rr_arbiter
   import fw_rv_rr_arbiter_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int N_REQ = 4,
   parameter int ID_W  = 2
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic [N_REQ*WIDTH-1:0] i_dat,
   input  logic [N_REQ-1:0]       i_valid,
`ifdef FW_RV_RR_ARBITER_LOCK_EN
   input  logic [N_REQ-1:0]       i_lock,
`endif
   output logic [N_REQ-1:0]       i_ready,
   output logic [WIDTH-1:0]       o_dat,
   output logic [ID_W-1:0]        o_id,
   output logic                   o_valid,
   input  logic                   o_ready
);

   localparam int MIN_ID_W = clog2(N_REQ);

   generate
      if (ID_W < MIN_ID_W) begin : g_id_w_check
         $error("fw_rv_rr_arbiter: ID_W too narrow for N_REQ");
      end
   endgenerate

   arb_state_e       state_reg, state_next;
   logic [ID_W-1:0]  owner_reg, owner_next;
   logic [ID_W-1:0]  rr_ptr_reg, rr_ptr_next;
   logic [WIDTH-1:0] o_dat_reg;
   logic [ID_W-1:0]  o_id_reg;
   logic             o_valid_reg;

   logic [WIDTH-1:0] dat_arr [N_REQ];
   logic [N_REQ-1:0] lock_req;
   logic [N_REQ-1:0] owner_hit;
   logic [N_REQ-1:0] gnt_onehot;
   logic [ID_W-1:0]  rr_gnt;
   logic [ID_W-1:0]  gnt;
   logic [ID_W-1:0]  gnt_inc;
   logic             rr_any;
   logic             any_req;
   logic             slot_free;
   logic             xfer;
   logic             gnt_lock;
   logic [WIDTH-1:0] gnt_dat;

`ifdef FW_RV_RR_ARBITER_LOCK_EN
   assign lock_req = i_lock;
`else
   assign lock_req = '0;
`endif

   fw_rv_rr_sel #(
      .N_REQ (N_REQ),
      .PTR_W (ID_W)
   ) u_sel (
      .req (i_valid),
      .ptr (rr_ptr_reg),
      .gnt (rr_gnt),
      .any (rr_any)
   );

   // While locked, only the owner may be granted; an idle owner still
   // blocks everyone else.
   assign gnt       = (state_reg == ARB_LOCKED) ? owner_reg : rr_gnt;
   assign any_req   = (state_reg == ARB_LOCKED) ? |owner_hit : rr_any;
   assign slot_free = !o_valid_reg || o_ready;
   assign xfer      = slot_free && any_req;
   assign gnt_inc   = (gnt == ID_W'(N_REQ - 1)) ? '0 : gnt + ID_W'(1);

   genvar gi;
   generate
      for (gi = 0; gi < N_REQ; gi++) begin : g_req
         assign dat_arr[gi]    = i_dat[gi*WIDTH +: WIDTH];
         assign owner_hit[gi]  = i_valid[gi] && (owner_reg == ID_W'(gi));
         assign gnt_onehot[gi] = (gnt == ID_W'(gi));
         assign i_ready[gi]    = xfer && gnt_onehot[gi];
      end
   endgenerate

   always_comb begin
      gnt_dat  = '0;
      gnt_lock = 1'b0;
      for (int i = 0; i < N_REQ; i++) begin
         if (gnt_onehot[i]) begin
            gnt_dat  = dat_arr[i];
            gnt_lock = lock_req[i];
         end
      end
   end

   // Lock FSM and round-robin pointer. The pointer moves only on accepted
   // transfers made while unlocked, plus once when a lock is released.
   always_comb begin
      state_next  = state_reg;
      owner_next  = owner_reg;
      rr_ptr_next = rr_ptr_reg;
      if (xfer) begin
         case (state_reg)
            ARB_UNLOCKED: begin
               rr_ptr_next = gnt_inc;
               if (gnt_lock) begin
                  state_next = ARB_LOCKED;
                  owner_next = gnt;
               end
            end
            ARB_LOCKED: begin
               if (!gnt_lock) begin
                  state_next  = ARB_UNLOCKED;
                  rr_ptr_next = gnt_inc;
               end
            end
            default: begin
               state_next = ARB_UNLOCKED;
            end
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         state_reg   <= ARB_UNLOCKED;
         owner_reg   <= '0;
         rr_ptr_reg  <= '0;
         o_valid_reg <= 1'b0;
         o_dat_reg   <= '0;
         o_id_reg    <= '0;
      end else begin
         state_reg  <= state_next;
         owner_reg  <= owner_next;
         rr_ptr_reg <= rr_ptr_next;
         // Fill wins over drain, so a drain+fill cycle keeps o_valid high.
         if (xfer) begin
            o_valid_reg <= 1'b1;
            o_dat_reg   <= gnt_dat;
            o_id_reg    <= gnt;
         end else if (o_ready) begin
            o_valid_reg <= 1'b0;
         end
      end
   end

   assign o_dat   = o_dat_reg;
   assign o_id    = o_id_reg;
   assign o_valid = o_valid_reg;

endmodule
